bias_buffer_pp: RTL

Parametrised, double-buffered (ping-pong) bias store for the NPU core. The AXI BRAM controller fills the shadow bank while the compute datapath streams bias words from the active bank. A start/length burst sequencer generates the read addresses, and a valid pipeline is matched to the RAM read latency. A swap handshake exchanges the two banks between layers without stalling either side.

---
 rtl/bias_buffer_pp_if.sv | 36 +++
 rtl/bias_buffer_pp.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/bias_buffer_pp_if.sv
// Bias buffer bus: BRAM-controller write port, swap handshake and burst read stream.
interface bias_buffer_pp_if #(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 8
);
  logic              i_bias_bramctl_en;
  logic              i_bias_bramctl_we;
  logic [ADDR_W-1:0] i_bias_bramctl_addr;
  logic [DATA_W-1:0] i_bias_bramctl_wdata;
  logic              i_bias_swap;
  logic              o_bias_swap_pend;
  logic              o_bias_active_bank;
  logic              i_bias_rd_start;
  logic [ADDR_W-1:0] i_bias_rd_base;
  logic [ADDR_W:0]   i_bias_rd_len;
  logic              o_bias_rd_busy;
  logic [DATA_W-1:0] o_bias_data;
  logic              o_bias_data_vld;
  logic              o_bias_rd_done;

  // Buffer side
  modport slave (
    input  i_bias_bramctl_en, i_bias_bramctl_we, i_bias_bramctl_addr, i_bias_bramctl_wdata,
    input  i_bias_swap, i_bias_rd_start, i_bias_rd_base, i_bias_rd_len,
    output o_bias_swap_pend, o_bias_active_bank, o_bias_rd_busy,
    output o_bias_data, o_bias_data_vld, o_bias_rd_done
  );

  // Controller / datapath side
  modport master (
    output i_bias_bramctl_en, i_bias_bramctl_we, i_bias_bramctl_addr, i_bias_bramctl_wdata,
    output i_bias_swap, i_bias_rd_start, i_bias_rd_base, i_bias_rd_len,
    input  o_bias_swap_pend, o_bias_active_bank, o_bias_rd_busy,
    input  o_bias_data, o_bias_data_vld, o_bias_rd_done
  );
endinterface

// File: rtl/bias_buffer_pp.sv
// Ping-pong bias store: the BRAM controller fills the shadow bank while a
// start/length burst sequencer streams words from the active bank. A bank swap
// requested mid-burst is deferred until the burst's last beat has left.
module bias_buffer_pp #(
  parameter int DATA_W = 512,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int RD_LAT = 1
) (
  input logic             clk,
  input logic             rst,
  bias_buffer_pp_if.slave bus
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  localparam logic [ADDR_W:0]   DEPTH_C    = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] DEPTH_A    = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A     = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   REM_ONE    = (ADDR_W+1)'(1);
  localparam logic [1:0]        DRAIN_INIT = 2'(RD_LAT - 1);

  logic [DATA_W-1:0] mem0 [DEPTH];
  logic [DATA_W-1:0] mem1 [DEPTH];

  state_t            state, state_nxt;
  logic              active_bank, swap_pend, rd_bank, zero_done;
  logic [ADDR_W-1:0] rd_addr_p0, base_mod;
  logic [ADDR_W:0]   remain;
  logic [1:0]        drain_cnt;
  logic              idle, start_acc, start_zero, issue_p0, last_p0, burst_end, wr;
  logic              vld_p1, last_p1;
  logic [DATA_W-1:0] data_p1;
  logic              vld_q, last_q;
  logic [DATA_W-1:0] data_q;

  assign idle       = (state == IDLE);
  assign start_acc  = idle && bus.i_bias_rd_start && (|bus.i_bias_rd_len);
  assign start_zero = idle && bus.i_bias_rd_start && !(|bus.i_bias_rd_len);
  assign issue_p0   = (state == READ);
  assign last_p0    = issue_p0 && (remain == REM_ONE);
  assign burst_end  = (state == DRAIN) && (drain_cnt == 2'd0);
  assign base_mod   = ({1'b0, bus.i_bias_rd_base} >= DEPTH_C) ?
                      (bus.i_bias_rd_base - DEPTH_A) : bus.i_bias_rd_base;
  assign wr         = bus.i_bias_bramctl_en && bus.i_bias_bramctl_we &&
                      ({1'b0, bus.i_bias_bramctl_addr} < DEPTH_C);

  // Sequencer state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Sequencer next-state: READ for len issues, DRAIN for RD_LAT cycles
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_acc) state_nxt = READ;
      READ:    if (remain == REM_ONE) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == 2'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Burst bookkeeping: address walk with wrap at DEPTH-1, remaining count, drain timer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_addr_p0 <= '0;
      remain     <= '0;
      drain_cnt  <= 2'd0;
      rd_bank    <= 1'b0;
      zero_done  <= 1'b0;
    end else begin
      zero_done <= start_zero;
      if (start_acc) begin
        rd_addr_p0 <= base_mod;
        remain     <= bus.i_bias_rd_len;
        // a swap on the same edge makes the burst read the new active bank
        rd_bank    <= active_bank ^ bus.i_bias_swap;
      end else if (issue_p0) begin
        rd_addr_p0 <= (rd_addr_p0 == LAST_A) ? '0 : rd_addr_p0 + ADDR_W'(1);
        remain     <= remain - REM_ONE;
        if (remain == REM_ONE) drain_cnt <= DRAIN_INIT;
      end else if ((state == DRAIN) && (drain_cnt != 2'd0)) begin
        drain_cnt <= drain_cnt - 2'd1;
      end
    end
  end

  // Swap handshake: immediate in IDLE, otherwise pending until the burst has drained
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_bank <= 1'b0;
      swap_pend   <= 1'b0;
    end else if (idle) begin
      if (bus.i_bias_swap) active_bank <= ~active_bank;
    end else if (burst_end) begin
      if (swap_pend || bus.i_bias_swap) active_bank <= ~active_bank;
      swap_pend <= 1'b0;
    end else if (bus.i_bias_swap) begin
      swap_pend <= 1'b1;
    end
  end

  // Controller writes land only in the shadow bank (pre-swap view on a swap edge)
  always_ff @(posedge clk) begin
    if (wr && active_bank)  mem0[bus.i_bias_bramctl_addr] <= bus.i_bias_bramctl_wdata;
    if (wr && !active_bank) mem1[bus.i_bias_bramctl_addr] <= bus.i_bias_bramctl_wdata;
  end

  // Stage p0 -> p1: registered RAM read; data holds between beats
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      data_p1 <= '0;
    end else begin
      vld_p1  <= issue_p0;
      last_p1 <= last_p0;
      if (issue_p0) data_p1 <= rd_bank ? mem1[rd_addr_p0] : mem0[rd_addr_p0];
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              vld_p2, last_p2;
      logic [DATA_W-1:0] data_p2;

      // Stage p1 -> p2: RAM output register for the two-cycle read
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          vld_p2  <= 1'b0;
          last_p2 <= 1'b0;
          data_p2 <= '0;
        end else begin
          vld_p2  <= vld_p1;
          last_p2 <= last_p1;
          if (vld_p1) data_p2 <= data_p1;
        end
      end

      assign vld_q  = vld_p2;
      assign last_q = last_p2;
      assign data_q = data_p2;
    end else begin : g_lat1
      assign vld_q  = vld_p1;
      assign last_q = last_p1;
      assign data_q = data_p1;
    end
  endgenerate

  assign bus.o_bias_data        = data_q;
  assign bus.o_bias_data_vld    = vld_q;
  assign bus.o_bias_rd_done     = (vld_q && last_q) || zero_done;
  assign bus.o_bias_rd_busy     = !idle;
  assign bus.o_bias_swap_pend   = swap_pend;
  assign bus.o_bias_active_bank = active_bank;

endmodule
